// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, datapath
// select codes and the FSM state type.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_RTYPE = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_FAULT     = 4'd12
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    // States that hold a memory strobe and wait on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles in a memory wait state and flags the
// cycle whose stall would exceed MEM_TIMEOUT (0 disables the check).
module mc_wait_timer #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in_wait,
    input  logic i_mem_ready,
    output logic o_timeout
);

    localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Leaving a wait state always clears, so every wait state is entered at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_in_wait || i_mem_ready) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
        end
    end

    assign o_timeout = (MEM_TIMEOUT != 0) && i_in_wait && !i_mem_ready &&
                       (r_cnt == LP_LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing MIPS R/ADDI/BEQ/J/LW/SW over 3-5 cycles on a shared-ALU,
// single-memory datapath, with memory-ready waits, timeout fault and retire count.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_2_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             fault,
    output logic [CNT_W-1:0] instr_retired
);

    state_t           r_state;
    state_t           w_next;
    logic             w_in_wait;
    logic             w_timeout;
    logic [CNT_W-1:0] r_retired;

    assign w_in_wait = is_wait_state(r_state);

    mc_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_wait   (w_in_wait),
        .i_mem_ready (mem_ready),
        .o_timeout   (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WR:    if (mem_ready) w_next = S_FETCH;
            S_EXEC:      w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_ADDI_WB:   w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_FAULT:     w_next = S_FAULT;
            default:     w_next = S_FETCH;
        endcase
        // The timer only fires while stalled, so a same-cycle mem_ready wins.
        if (w_timeout) w_next = S_FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        fault         = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // Gated by rst_n so no PC/IR load is signalled while in reset.
                pc_write  = mem_ready && rst_n;
                ir_write  = mem_ready && rst_n;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = !is_legal_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                mem_2_reg  = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (instr_done) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign instr_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected control words
// queued as each cycle is driven and compared at the falling edge.
module tb_multicycle_control_unit;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [5:0]    opcode = 6'h00;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic          reg_dst, mem_2_reg, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic          instr_done, illegal_op, fault;
    logic [CW-1:0] instr_retired;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .MEM_TIMEOUT (TO),
        .TIMEOUT_W   (8),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_2_reg     (mem_2_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .fault         (fault),
        .instr_retired (instr_retired)
    );

    logic [18:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_2_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, instr_done, illegal_op, fault};

    logic [18:0]   exp_q[$];
    string         tag_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_ret = '0;

    function automatic logic [18:0] cw(input logic pcw, pcwc, iord, mrd, mwr, irw,
                                       input logic rdst, m2r, rw, asa,
                                       input logic [1:0] asb, aop, pcs,
                                       input logic done, ill, flt);
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs,
                done, ill, flt};
    endfunction

    function automatic logic [18:0] w_fetch(input logic mr);
        return cw(mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'd0, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [18:0] w_decode(input logic ill);
        return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'd0, 2'b00, 0, ill, 0);
    endfunction
    function automatic logic [18:0] w_memwr(input logic mr);
        return cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'b00, mr, 0, 0);
    endfunction

    logic [18:0] W_RESET, W_MADDR, W_MRD, W_MWB, W_EXEC, W_RWB, W_AEXEC, W_AWB;
    logic [18:0] W_BRANCH, W_JUMP, W_FAULT;
    initial begin
        W_RESET  = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'd0, 2'b00, 0, 0, 0);
        W_MADDR  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'd0, 2'b00, 0, 0, 0);
        W_MRD    = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'b00, 0, 0, 0);
        W_MWB    = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'd0, 2'b00, 1, 0, 0);
        W_EXEC   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'd2, 2'b00, 0, 0, 0);
        W_RWB    = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'd0, 2'b00, 1, 0, 0);
        W_AEXEC  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'd0, 2'b00, 0, 0, 0);
        W_AWB    = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'd0, 2'b00, 1, 0, 0);
        W_BRANCH = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'd1, 2'b01, 1, 0, 0);
        W_JUMP   = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'b10, 1, 0, 0);
        W_FAULT  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 2'b00, 0, 0, 1);
    end

    task automatic sample_ctrl();
        logic [18:0] ev;
        string       t;
        ev = exp_q.pop_front();
        t  = tag_q.pop_front();
        n_checks++;
        assert (ctrl === ev) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", t, ctrl, ev);
        end
    endtask

    // Drive one cycle starting just after a rising edge; compare mid-cycle.
    task automatic cyc(input logic mr, input logic [18:0] e, input string tag);
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        sample_ctrl();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input logic [18:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        sample_ctrl();
    endtask

    task automatic check_ret(input string tag);
        n_checks++;
        assert (instr_retired === exp_ret) else begin
            n_fail++;
            $error("FAIL %s: retired observed=%0d expected=%0d", tag, instr_retired, exp_ret);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        exp_ret   = '0;
        expect_now(W_RESET, "reset_async");
        check_ret("reset_cnt");
        repeat (2) @(posedge clk);
        expect_now(W_RESET, "reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int waits);
        logic ill;
        ill    = !(op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
        opcode = op;
        cyc(1, w_fetch(1), "fetch");
        cyc(1, w_decode(ill), "decode");
        case (op)
            6'h00: begin cyc(1, W_EXEC, "exec"); cyc(1, W_RWB, "r_wb"); end
            6'h08: begin cyc(1, W_AEXEC, "addi_exec"); cyc(1, W_AWB, "addi_wb"); end
            6'h04: cyc(1, W_BRANCH, "branch");
            6'h02: cyc(1, W_JUMP, "jump");
            6'h23: begin
                cyc(1, W_MADDR, "lw_addr");
                repeat (waits) cyc(0, W_MRD, "mem_rd_wait");
                cyc(1, W_MRD, "mem_rd");
                cyc(1, W_MWB, "mem_wb");
            end
            6'h2B: begin
                cyc(1, W_MADDR, "sw_addr");
                repeat (waits) cyc(0, w_memwr(0), "mem_wr_wait");
                cyc(1, w_memwr(1), "mem_wr");
            end
            default: ;
        endcase
        if (!ill) exp_ret = exp_ret + CW'(1);
        check_ret($sformatf("retired_op%02h", op));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        run_instr(6'h00, 0);
        run_instr(6'h23, 3);
        run_instr(6'h04, 0);
        run_instr(6'h02, 0);
        run_instr(6'h08, 0);
        run_instr(6'h2B, 1);
        run_instr(6'h3F, 0);
        // Drive the narrow retire counter through its wrap.
        repeat (12) run_instr(6'h02, 0);

        // Timeout: stalled fetch faults after TO+1 cycles and stays faulted.
        do_reset();
        opcode = 6'h02;
        repeat (TO + 1) cyc(0, w_fetch(0), "fetch_stall");
        cyc(0, W_FAULT, "fault_enter");
        cyc(1, W_FAULT, "fault_sticky1");
        cyc(1, W_FAULT, "fault_sticky2");
        check_ret("fault_cnt");

        // mem_ready on the last permitted stall cycle beats the timeout.
        do_reset();
        repeat (TO) cyc(0, w_fetch(0), "fetch_stall_ok");
        cyc(1, w_fetch(1), "fetch_ready_edge");
        cyc(1, w_decode(0), "decode_after_edge");
        cyc(1, W_JUMP, "jump_after_edge");
        exp_ret = exp_ret + CW'(1);
        check_ret("edge_cnt");

        // Reset in the middle of a store wait.
        do_reset();
        opcode = 6'h2B;
        cyc(1, w_fetch(1), "sw_fetch");
        cyc(1, w_decode(0), "sw_decode");
        cyc(1, W_MADDR, "sw_addr");
        cyc(0, w_memwr(0), "sw_wait");
        mem_ready = 1'b0;
        expect_now(w_memwr(0), "sw_still_wr");
        do_reset();
        cyc(0, w_fetch(0), "post_rst_fetch1");
        cyc(0, w_fetch(0), "post_rst_fetch2");
        check_ret("post_rst_cnt");
        run_instr(6'h02, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle successor to the single-cycle control decoder. A Moore state machine sequences each MIPS instruction (R-type, ADDI, BEQ, J, LW, SW) over 3–5 cycles, with wait states on a memory ready handshake. It adds a memory-timeout fault and a retired-instruction counter. It sits between the instruction register and the shared-ALU/single-memory multicycle datapath.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive wait cycles before a fault is raised; 0 disables the timeout.
- `TIMEOUT_W`, default 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^TIMEOUT_W.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `opcode` in 6: instr[31:26], taken from the instruction register.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by ALU zero.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes, held until `mem_ready`.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: register-file write destination; 1 = rd, 0 = rt.
- `mem_2_reg` out 1: write-back source; 1 = MDR, 0 = ALUOut.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op` out 2: 0 = ADD, 1 = SUB, 2 = R_TYPE.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: final cycle of a retiring instruction.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `fault` out 1: sticky memory-timeout fault.
- `instr_retired` out CNT_W: count of retired instructions.

## Operation
- Opcodes: R 0x00, J 0x02, BEQ 0x04, ADDI 0x08, LW 0x23, SW 0x2B.
- Outputs are a pure function of the state (Moore). Exceptions: `pc_write`/`ir_write` in FETCH and `instr_done` in MEM_WR are ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, ir_write=pc_write=mem_ready. Stay while `mem_ready`=0; otherwise go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD. Next state by opcode:
  - LW/SW → MEM_ADDR
  - R → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDI_EXEC
  - other → FETCH, with `illegal_op`=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Go to MEM_RD if LW, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1, instr_done=1; go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for `mem_ready`, then go to FETCH (instr_done=mem_ready).
- EXEC: alu_src_a=1, alu_src_b=00, R_TYPE; go to R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1; go to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD; go to ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1, instr_done=1; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, instr_done=1; go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; go to FETCH.
- FAULT: all strobes 0, fault=1. Exit only by reset.
- Wait counter:
  - Clears on entry to any wait state (FETCH, MEM_RD, MEM_WR) and whenever `mem_ready`=1.
  - Increments each cycle spent in a wait state with `mem_ready`=0.
  - When the count equals MEM_TIMEOUT (and MEM_TIMEOUT≠0) with `mem_ready` still 0, next state is FAULT.
  - If `mem_ready` arrives in that same cycle, `mem_ready` wins.
- `instr_retired` increments when `instr_done`=1 and wraps modulo 2^CNT_W. Illegal opcodes do not count.

## Timing
- Reset: state FETCH, wait counter 0, `instr_retired` 0, `fault` 0.
  - During reset, FETCH decodes mem_read=1, alu_src_b=01, and all other outputs 0.
- Deasserting reset mid-instruction abandons that instruction; the first active cycle is FETCH.
- Cycles with zero wait: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each wait cycle adds one cycle.
- `opcode` is sampled only in DECODE and MEM_ADDR; it must be stable from the IR load onward.
- The counter update is visible the cycle after `instr_done`.

## Structure
- Package `mc_ctrl_pkg`:
  - opcode constants
  - alu_op encodings (ADD/SUB/R_TYPE)
  - alu_src_b and pc_source encodings
  - state enum (13 states, 4-bit)
- One natural sub-module, `mc_wait_timer`: wait counter plus timeout compare, parametrised by TIMEOUT_W and MEM_TIMEOUT.

## Test plan
- Reset, then opcode 0x00 with `mem_ready` tied 1 → states FETCH, DECODE, EXEC, R_WB; reg_dst=1 and reg_write=1 in cycle 4; `instr_retired` is 1 afterwards.
- LW (0x23) with `mem_ready` low for 3 cycles in MEM_RD → 8 total cycles; mem_read held through the wait; mem_2_reg=1 and reg_write=1 in the last cycle.
- BEQ (0x04), then J (0x02) → 3 cycles each; pc_write_cond=1 with pc_source=01, then pc_write=1 with pc_source=10; counter increases by 2.
- Opcode 0x3F → `illegal_op` pulses in DECODE; returns to FETCH; counter unchanged.
- MEM_TIMEOUT=4 with `mem_ready` held 0 in FETCH → `fault`=1 after 5 cycles and stays sticky. A second run with `mem_ready` rising on exactly the 5th cycle reaches DECODE and no fault is raised.
- `rst_n` asserted mid-SW in MEM_WR → outputs immediately show reset values; after release the sequence restarts at FETCH and mem_write never pulses.
